// File: rtl/upsample2x_stream.sv
// upsample2x_stream: streaming nearest-neighbour 2x upsampler.
// Takes an InputH x InputW map of elements in row-major order, one element
// per beat, and produces the 2*InputH x 2*InputW map one element per beat.
// In ROW0 each element is emitted twice as it arrives and is also stored in
// a line buffer. In ROW1 the stored row is replayed, again twice per element.
// Element bit patterns are passed through unchanged.
//
// Optional build macro: UPSAMPLE_FRAME_CNT_EN adds a 32-bit frame_cnt output
// that counts completed output frames. Without the macro that port and its
// counter are absent, and the data path behaves the same.
module upsample2x_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int InputH     = 13,
    parameter int InputW     = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef UPSAMPLE_FRAME_CNT_EN
    output logic [31:0]           frame_cnt,
`endif
    output logic                  out_last
);

    // acc counts 0..InputW, so it needs one state more than the column index.
    localparam int ACC_W = $clog2(InputW + 1);
    localparam int COL_W = (InputW > 1) ? $clog2(InputW) : 1;
    localparam int ROW_W = (InputH > 1) ? $clog2(InputH) : 1;

    localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(InputW);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(InputW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(InputH - 1);

    // ROW0 passes the live row through; ROW1 replays it from the line buffer.
    typedef enum logic {
        ROW0 = 1'b0,
        ROW1 = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pix_q, pix_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic                    dup_q, dup_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0]   lb_q [InputW];
    logic                    lb_we;
    logic [COL_W-1:0]        lb_waddr;

    logic                    in_xfer;
    logic                    out_xfer;

    // An output beat leaves whenever the held element meets a ready downstream.
    assign out_xfer  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;

    // The frame ends on the second copy of the last replayed element of the last row.
    assign out_last = (state_q == ROW1) && (row_q == ROW_LAST) &&
                      (col_q == COL_LAST) && dup_q;

    // Next-state and output decode for the row FSM and its counters.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        pix_d       = pix_q;
        acc_d       = acc_q;
        col_d       = col_q;
        dup_d       = dup_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        in_xfer     = 1'b0;
        out_data    = pix_q;
        lb_we       = 1'b0;
        lb_waddr    = acc_q[COL_W-1:0];

        case (state_q)
            ROW0: begin
                // A new element may enter when the output is empty, or in the
                // same cycle that the second copy of the current one leaves.
                in_ready = (acc_q < ACC_FULL) &&
                           (!out_valid_q || (out_ready && dup_q));
                in_xfer  = in_valid && in_ready;
                out_data = pix_q;

                if (in_xfer) begin
                    pix_d       = in_data;
                    lb_we       = 1'b1;
                    acc_d       = acc_q + ACC_W'(1);
                    out_valid_d = 1'b1;
                    dup_d       = 1'b0;
                end else if (out_xfer) begin
                    if (!dup_q) begin
                        dup_d = 1'b1;
                    end else if (acc_q == ACC_FULL) begin
                        // The row is complete, so start the replay. out_valid
                        // stays high to avoid a bubble going into ROW1.
                        state_d = ROW1;
                        col_d   = '0;
                        dup_d   = 1'b0;
                    end else begin
                        // Second copy is gone and nothing new arrived.
                        out_valid_d = 1'b0;
                    end
                end
            end

            ROW1: begin
                out_data = lb_q[col_q];

                if (out_xfer) begin
                    dup_d = !dup_q;
                    if (dup_q) begin
                        col_d = col_q + COL_W'(1);
                        if (col_q == COL_LAST) begin
                            // Replay is done: return to the live row with one bubble.
                            col_d       = '0;
                            acc_d       = '0;
                            state_d     = ROW0;
                            out_valid_d = 1'b0;
                            row_d       = (row_q == ROW_LAST) ? '0
                                                              : row_q + ROW_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ROW0;
            end
        endcase
    end

    // Control and data registers with a synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values that were present before the edge.
        if (reset) begin
            state_q     <= ROW0;
            pix_q       <= '0;
            acc_q       <= '0;
            col_q       <= '0;
            dup_q       <= 1'b0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            acc_q       <= acc_d;
            col_q       <= col_d;
            dup_q       <= dup_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Line buffer: stores the live row for replay.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset. Every entry is written in ROW0 before
        // ROW1 reads it, so stale contents are never observed.
        if (lb_we) begin
            lb_q[lb_waddr] <= in_data;
        end
    end

`ifdef UPSAMPLE_FRAME_CNT_EN
    logic [31:0] frame_cnt_q;

    // Count completed output frames; the counter wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (out_xfer && out_last) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_upsample2x_stream.sv
// Testbench for upsample2x_stream: a 2x2 instance (A) and a default 13x13
// instance (B). Stimulus tasks push expected beats into per-instance queues,
// and negedge monitors pop and compare them on every output transfer.
module tb_upsample2x_stream;

    localparam int DW = 16;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 2x2
    logic          reset_a;
    logic [DW-1:0] in_data_a;
    logic          in_valid_a;
    logic          in_ready_a;
    logic [DW-1:0] out_data_a;
    logic          out_valid_a;
    logic          out_ready_a;
    logic          out_last_a;
`ifdef UPSAMPLE_FRAME_CNT_EN
    logic [31:0]   frame_cnt_a;
    logic [31:0]   frame_cnt_b;
`endif

    // Instance B: 13x13
    logic          reset_b;
    logic [DW-1:0] in_data_b;
    logic          in_valid_b;
    logic          in_ready_b;
    logic [DW-1:0] out_data_b;
    logic          out_valid_b;
    logic          out_ready_b;
    logic          out_last_b;

    upsample2x_stream #(.DATA_WIDTH(DW), .InputH(2), .InputW(2)) dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
`ifdef UPSAMPLE_FRAME_CNT_EN
        .frame_cnt (frame_cnt_a),
`endif
        .out_last  (out_last_a)
    );

    upsample2x_stream #(.DATA_WIDTH(DW), .InputH(13), .InputW(13)) dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
`ifdef UPSAMPLE_FRAME_CNT_EN
        .frame_cnt (frame_cnt_b),
`endif
        .out_last  (out_last_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   mon_en_a = 1'b1;
    bit   rand_a   = 1'b0;

    // Per-frame statistics gathered by the B monitor.
    int idx_b      = 0;
    int cnt4500_b  = 0;
    int cnt_last_b = 0;
    int row1_viol  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Nearest-neighbour expectation: output (r,c) equals input (r/2,c/2).
    task automatic push_model(input int h, input int w, input logic [DW-1:0] f[$],
                              input bit to_b);
        exp_t e;
        for (int r = 0; r < 2 * h; r++) begin
            for (int c = 0; c < 2 * w; c++) begin
                e.data = f[(r / 2) * w + (c / 2)];
                e.last = (r == 2 * h - 1) && (c == 2 * w - 1);
                if (to_b) q_b.push_back(e);
                else      q_a.push_back(e);
            end
        end
    endtask

    // Hand-computed 2x2 result for inputs 4000,4200,4500,3C00.
    task automatic push_s1;
        logic [DW-1:0] s1_exp [16];
        exp_t e;
        s1_exp = '{16'h4000, 16'h4000, 16'h4200, 16'h4200,
                   16'h4000, 16'h4000, 16'h4200, 16'h4200,
                   16'h4500, 16'h4500, 16'h3C00, 16'h3C00,
                   16'h4500, 16'h4500, 16'h3C00, 16'h3C00};
        for (int i = 0; i < 16; i++) begin
            e.data = s1_exp[i];
            e.last = (i == 15);
            q_a.push_back(e);
        end
    endtask

    task automatic send_a(input logic [DW-1:0] v);
        int n;
        n          = 0;
        in_data_a  = v;
        in_valid_a = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) begin
            fail_now("send_a timeout");
            in_valid_a = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [DW-1:0] v);
        int n;
        n          = 0;
        in_data_b  = v;
        in_valid_b = 1'b1;
        @(negedge clk);
        while (!in_ready_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_b) begin
            fail_now("send_b timeout");
            in_valid_b = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain_a;
        int n;
        n = 0;
        while (q_a.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain_a", 32'(q_a.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_b;
        int n;
        n = 0;
        while (q_b.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_b", 32'(q_b.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks_a(input string tag);
        check({tag, " out_valid"}, 32'(out_valid_a), 32'd0);
        check({tag, " out_last"},  32'(out_last_a),  32'd0);
        check({tag, " in_ready"},  32'(in_ready_a),  32'd1);
        check({tag, " out_data"},  32'(out_data_a),  32'd0);
    endtask

    // Random out_ready generator for instance A.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_a) out_ready_a = 1'($urandom_range(0, 1));
        end
    end

    // Monitor A: scoreboard compare plus hold-stability while stalled.
    initial begin
        bit            held;
        logic [DW-1:0] held_data;
        logic          held_last;
        exp_t          e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_a) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_a", 32'({out_valid_a, out_last_a, out_data_a}),
                          32'({1'b1, held_last, held_data}));
                end
                held      = out_valid_a && !out_ready_a;
                held_data = out_data_a;
                held_last = out_last_a;
                if (out_valid_a && out_ready_a && mon_en_a) begin
                    if (q_a.size() == 0) begin
                        fail_now("out_a unexpected beat");
                    end else begin
                        e = q_a.pop_front();
                        check("out_a", 32'({out_last_a, out_data_a}),
                              32'({e.last, e.data}));
                    end
                end
            end
        end
    end

    // Monitor B: scoreboard compare plus per-frame statistics.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                // Odd output rows are replay rows, so the input must be held off.
                if (out_valid_b && ((idx_b / 26) % 2 == 1) && in_ready_b)
                    row1_viol++;
                if (out_valid_b && out_ready_b) begin
                    if (out_data_b == 16'h4500) cnt4500_b++;
                    if (out_last_b) cnt_last_b++;
                    idx_b = (idx_b == 675) ? 0 : idx_b + 1;
                    if (q_b.size() == 0) begin
                        fail_now("out_b unexpected beat");
                    end else begin
                        e = q_b.pop_front();
                        check("out_b", 32'({out_last_b, out_data_b}),
                              32'({e.last, e.data}));
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] f[$];

        reset_a = 1'b1; in_data_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        reset_b = 1'b1; in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_checks_a("reset");

        // Scenario 1: 2x2 with out_ready held high.
        push_s1();
        send_a(16'h4000);
        check("latency valid", 32'(out_valid_a), 32'd1);
        check("latency data",  32'(out_data_a),  32'h4000);
        send_a(16'h4200);
        send_a(16'h4500);
        send_a(16'h3C00);
        drain_a();

        // Scenario 2: 13x13 with a single distinct element at (6,6).
        f = {};
        for (int i = 0; i < 169; i++) f.push_back((i == 6 * 13 + 6) ? 16'h4500 : 16'h4000);
        push_model(13, 13, f, 1'b1);
        for (int i = 0; i < 169; i++) send_b(f[i]);
        drain_b();
        check("b 4500 count", 32'(cnt4500_b), 32'd4);
        check("b last count", 32'(cnt_last_b), 32'd1);
        check("b in_ready in replay", 32'(row1_viol), 32'd0);
        check("b frame position", 32'(idx_b), 32'd0);

        // Scenario 3: 2x2 with random out_ready.
        f = {16'h4000, 16'h4200, 16'h4500, 16'h3C00};
        push_model(2, 2, f, 1'b0);
        rand_a = 1'b1;
        for (int i = 0; i < 4; i++) send_a(f[i]);
        drain_a();
        rand_a      = 1'b0;
        out_ready_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Scenario 4: input gap after the first element.
        f = {16'h3C00, 16'h4400, 16'h4800, 16'h4A00};
        push_model(2, 2, f, 1'b0);
        send_a(f[0]);
        @(posedge clk);
        #1;
        check("gap dup0 valid", 32'(out_valid_a), 32'd1);
        @(posedge clk);
        #1;
        check("gap bubble", 32'(out_valid_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("gap idle", 32'(out_valid_a), 32'd0);
        send_a(f[1]);
        check("gap resume valid", 32'(out_valid_a), 32'd1);
        check("gap resume data",  32'(out_data_a),  32'(f[1]));
        send_a(f[2]);
        send_a(f[3]);
        drain_a();

        // Scenario 5: reset after three outputs, then a clean frame.
        mon_en_a = 1'b0;
        send_a(16'h5000);
        send_a(16'h5100);
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_checks_a("midreset");
        mon_en_a = 1'b1;
        push_s1();
        send_a(16'h4000);
        send_a(16'h4200);
        send_a(16'h4500);
        send_a(16'h3C00);
        drain_a();

`ifdef UPSAMPLE_FRAME_CNT_EN
        // Scenario 6: frame counter over three frames, then reset.
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        check("frame_cnt reset", frame_cnt_a, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            f = {16'(16'h1000 + k), 16'(16'h2000 + k), 16'(16'h3000 + k), 16'(16'h4000 + k)};
            push_model(2, 2, f, 1'b0);
            for (int i = 0; i < 4; i++) send_a(f[i]);
            drain_a();
            check("frame_cnt", frame_cnt_a, 32'(k));
        end
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        check("frame_cnt after reset", frame_cnt_a, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
